// File: rtl/adbg_core_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adbg_core_dbg_pkg
//  Description : Shared constants, FSM state type and address helpers for the
//                per-core debug unit (address map, CTRL/STATUS bit positions,
//                register-file select values).
//  Revision    : 1.0 - initial release
// ============================================================================
package adbg_core_dbg_pkg;

  // Debug-bus byte addresses
  localparam logic [15:0] ADDR_CTRL     = 16'h0000;
  localparam logic [15:0] ADDR_STATUS   = 16'h0004;
  localparam logic [15:0] ADDR_PC       = 16'h0008;
  localparam logic [15:0] ADDR_GPR_BASE = 16'h0400;
  localparam logic [15:0] ADDR_GPR_LAST = 16'h047C;

  // CTRL bit positions
  localparam int CTRL_HALT = 0;
  localparam int CTRL_SSTE = 1;

  // STATUS bit positions
  localparam int STAT_HALTED   = 0;
  localparam int STAT_STEP_DONE = 1;
  localparam int STAT_ERR      = 2;

  // Register-file select for the program counter
  localparam logic [5:0] RF_SEL_PC = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOCAL   = 3'd1,
    ST_RF_REQ  = 3'd2,
    ST_RF_WAIT = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  // True for PC and word-aligned GPR addresses
  function automatic logic is_core_reg(input logic [15:0] a);
    return (a == ADDR_PC) ||
           ((a >= ADDR_GPR_BASE) && (a <= ADDR_GPR_LAST) && (a[1:0] == 2'b00));
  endfunction

  // Register-file index for a core-register address
  function automatic logic [5:0] rf_sel(input logic [15:0] a);
    return (a == ADDR_PC) ? RF_SEL_PC : 6'((a - ADDR_GPR_BASE) >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adbg_core_dbg_unit.sv
`default_nettype none
// ============================================================================
//  Module      : adbg_core_dbg_unit
//  Description : Per-core debug target. Serves CPU debug-bus requests from the
//                local CTRL/STATUS registers or from the core register file
//                (req/gnt/rvalid), and owns halt / single-step of the core.
//  Revision    : 1.0 - initial release
// ============================================================================
module adbg_core_dbg_unit
  import adbg_core_dbg_pkg::*;
#(
  parameter int unsigned RF_TIMEOUT = 255
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic [15:0] dbg_addr_i,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_we_i,
  input  logic        dbg_stb_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_data_o,
  output logic        dbg_halt_o,
  output logic        dbg_step_o,
  input  logic        core_halted_i,
  output logic        rf_req_o,
  output logic        rf_we_o,
  output logic [5:0]  rf_addr_o,
  output logic [31:0] rf_wdata_o,
  input  logic        rf_gnt_i,
  input  logic        rf_rvalid_i,
  input  logic [31:0] rf_rdata_i
);

  // Last RF_WAIT count before giving up: the ack then lands RF_TIMEOUT+1
  // cycles after the grant.
  localparam logic [7:0] TMO_LAST = 8'(RF_TIMEOUT - 1);

  state_t      state;
  logic [15:0] addr_q;
  logic [31:0] rdata;
  logic [7:0]  tmo_cnt;
  logic        ctrl_halt;
  logic        ctrl_sste;
  logic        step;
  logic        step_pend;
  logic        step_armed;
  logic        step_done;
  logic        err;
  logic        halted_prev;

  // Outputs decoded from the state register or driven straight from flops
  assign dbg_ack_o  = (state == ST_ACK);
  assign rf_req_o   = (state == ST_RF_REQ);
  assign dbg_data_o = rdata;
  assign dbg_halt_o = ctrl_halt;
  assign dbg_step_o = step;

  // Transaction FSM plus control/status register bookkeeping
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      rdata       <= '0;
      tmo_cnt     <= '0;
      ctrl_halt   <= 1'b0;
      ctrl_sste   <= 1'b0;
      step        <= 1'b0;
      step_pend   <= 1'b0;
      step_armed  <= 1'b0;
      step_done   <= 1'b0;
      err         <= 1'b0;
      halted_prev <= 1'b0;
      rf_we_o     <= 1'b0;
      rf_addr_o   <= '0;
      rf_wdata_o  <= '0;
    end else begin
      halted_prev <= core_halted_i;

      // Core re-halting after a step marks the step complete
      if (step_armed && core_halted_i && !halted_prev) begin
        step_done  <= 1'b1;
        step_armed <= 1'b0;
      end

      // The step pulse lasts one cycle, after which halt is requested again
      if (step) begin
        step      <= 1'b0;
        ctrl_halt <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (dbg_stb_i) begin
            addr_q     <= dbg_addr_i;
            rf_we_o    <= dbg_we_i;
            rf_wdata_o <= dbg_data_i;
            rf_addr_o  <= rf_sel(dbg_addr_i);
            state      <= (is_core_reg(dbg_addr_i) && core_halted_i) ? ST_RF_REQ : ST_LOCAL;
          end
        end

        ST_LOCAL: begin
          rdata <= '0;
          if (is_core_reg(addr_q)) begin
            // Core register touched while the core runs: refused
            err <= 1'b1;
          end else if (addr_q == ADDR_CTRL) begin
            if (rf_we_o) begin
              ctrl_sste <= rf_wdata_o[CTRL_SSTE];
              step_done <= 1'b0;
              if (!rf_wdata_o[CTRL_HALT] && rf_wdata_o[CTRL_SSTE] && core_halted_i)
                step_pend <= 1'b1;  // halt drops together with the step pulse, after ack
              else
                ctrl_halt <= rf_wdata_o[CTRL_HALT];
            end else begin
              rdata <= {30'b0, ctrl_sste, ctrl_halt};
            end
          end else if (addr_q == ADDR_STATUS) begin
            if (rf_we_o) begin
              if (rf_wdata_o[STAT_ERR])
                err <= 1'b0;
            end else begin
              rdata <= {29'b0, err, step_done, core_halted_i};
            end
          end
          state <= ST_ACK;
        end

        ST_RF_REQ: begin
          tmo_cnt <= '0;
          if (rf_gnt_i) begin
            if (rf_we_o) begin
              state <= ST_ACK;
            end else if (rf_rvalid_i) begin
              rdata <= rf_rdata_i;
              state <= ST_ACK;
            end else begin
              state <= ST_RF_WAIT;
            end
          end
        end

        ST_RF_WAIT: begin
          if (rf_rvalid_i) begin
            rdata <= rf_rdata_i;
            state <= ST_ACK;
          end else if (tmo_cnt == TMO_LAST) begin
            rdata <= '0;
            err   <= 1'b1;
            state <= ST_ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        ST_ACK: begin
          rdata <= '0;
          state <= ST_IDLE;
          if (step_pend) begin
            step_pend  <= 1'b0;
            step       <= 1'b1;
            ctrl_halt  <= 1'b0;
            step_armed <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adbg_core_dbg_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adbg_core_dbg_unit
//  Description : Self-checking bench for adbg_core_dbg_unit: directed steps
//                followed by randomized debug-bus traffic against a
//                register-level model of CTRL/STATUS and the access timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adbg_core_dbg_unit;

  localparam int RF_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dbg_addr_i;
  logic [31:0] dbg_data_i;
  logic        dbg_we_i;
  logic        dbg_stb_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_data_o;
  logic        dbg_halt_o;
  logic        dbg_step_o;
  logic        core_halted_i;
  logic        rf_req_o;
  logic        rf_we_o;
  logic [5:0]  rf_addr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_gnt_i;
  logic        rf_rvalid_i;
  logic [31:0] rf_rdata_i;

  adbg_core_dbg_unit #(.RF_TIMEOUT(RF_TIMEOUT)) dut (
    .cpu_clk_i     (clk),
    .cpu_rst_i     (rst),
    .dbg_addr_i    (dbg_addr_i),
    .dbg_data_i    (dbg_data_i),
    .dbg_we_i      (dbg_we_i),
    .dbg_stb_i     (dbg_stb_i),
    .dbg_ack_o     (dbg_ack_o),
    .dbg_data_o    (dbg_data_o),
    .dbg_halt_o    (dbg_halt_o),
    .dbg_step_o    (dbg_step_o),
    .core_halted_i (core_halted_i),
    .rf_req_o      (rf_req_o),
    .rf_we_o       (rf_we_o),
    .rf_addr_o     (rf_addr_o),
    .rf_wdata_o    (rf_wdata_o),
    .rf_gnt_i      (rf_gnt_i),
    .rf_rvalid_i   (rf_rvalid_i),
    .rf_rdata_i    (rf_rdata_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural register contents
  logic m_halt, m_sste, m_err, m_step_done;

  // Observations from the last transaction
  int          o_ack_c, o_req_c, o_first_req, o_steps;
  logic [31:0] o_data;
  logic [5:0]  o_ra;
  logic        o_rw, o_unstable, o_extra_ack, o_halt_ack, o_halt_x;
  logic [31:0] o_rwd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_core(input logic [15:0] a);
    return (a == 16'h0008) || (a >= 16'h0400 && a <= 16'h047C && (a % 4) == 0);
  endfunction

  function automatic logic [5:0] m_rf_index(input logic [15:0] a);
    int idx;
    idx = (a == 16'h0008) ? 32 : (int'(a) - 'h400) / 4;
    return 6'(idx);
  endfunction

  function automatic logic [31:0] m_local_read(input logic [15:0] a);
    if (a == 16'h0000) return {30'b0, m_sste, m_halt};
    if (a == 16'h0004) return {29'b0, m_err, m_step_done, core_halted_i};
    return 32'h0;
  endfunction

  // Drive one debug-bus request and act as the register file; records timing
  // relative to the cycle in which the strobe is first sampled (cycle 0).
  task automatic run_txn(input logic [15:0] a, input logic w, input logic [31:0] d,
                         input int gdly, input int rdly, input bit rnever,
                         input logic [31:0] rval);
    int c, gnt_c;
    bit done;
    o_ack_c = -1; o_req_c = 0; o_first_req = -1; o_steps = 0; o_data = '0;
    o_ra = '0; o_rw = 1'b0; o_rwd = '0; o_unstable = 1'b0; o_extra_ack = 1'b0;
    o_halt_ack = 1'b0; o_halt_x = 1'b0;
    gnt_c = -1; done = 0; c = 0;
    dbg_addr_i = a; dbg_we_i = w; dbg_data_i = d; dbg_stb_i = 1'b1;
    while (!done && c < 400) begin
      @(posedge clk); #1; c++;
      rf_gnt_i = 1'b0; rf_rvalid_i = 1'b0; rf_rdata_i = $urandom;
      if (dbg_step_o) o_steps++;
      if (dbg_ack_o) begin
        o_ack_c = c; o_data = dbg_data_o; o_halt_ack = dbg_halt_o;
        dbg_stb_i = 1'b0; done = 1;
      end else begin
        if (rf_req_o) begin
          if (o_first_req < 0) begin
            o_first_req = c; o_ra = rf_addr_o; o_rw = rf_we_o; o_rwd = rf_wdata_o;
          end else if (rf_addr_o !== o_ra || rf_we_o !== o_rw || rf_wdata_o !== o_rwd) begin
            o_unstable = 1'b1;
          end
          o_req_c++;
          if (o_req_c - 1 == gdly) begin rf_gnt_i = 1'b1; gnt_c = c; end
        end
        if (gnt_c >= 0 && !w && !rnever && c - gnt_c == rdly) begin
          rf_rvalid_i = 1'b1; rf_rdata_i = rval;
        end
      end
    end
    dbg_stb_i = 1'b0; rf_gnt_i = 1'b0; rf_rvalid_i = 1'b0;
    @(posedge clk); #1;
    if (dbg_ack_o) o_extra_ack = 1'b1;
    if (dbg_step_o) o_steps++;
    o_halt_x = dbg_halt_o;
  endtask

  // Run a non-step transaction, check it against the model, update the model
  task automatic expect_txn(input string tag, input logic [15:0] a, input logic w,
                            input logic [31:0] d, input int gdly, input int rdly,
                            input bit rnever, input logic [31:0] rval);
    logic [31:0] exp_local;
    bit to_rf;
    to_rf = m_is_core(a) && core_halted_i;
    exp_local = m_local_read(a);
    run_txn(a, w, d, gdly, rdly, rnever, rval);
    if (to_rf) begin
      chk({tag, " req_start"}, o_first_req, 1);
      chk({tag, " req_cycles"}, o_req_c, gdly + 1);
      chk({tag, " rf_addr"}, {26'b0, o_ra}, {26'b0, m_rf_index(a)});
      chk({tag, " rf_we"}, {31'b0, o_rw}, {31'b0, w});
      chk({tag, " rf_stable"}, {31'b0, o_unstable}, 32'h0);
      if (w) begin
        chk({tag, " rf_wdata"}, o_rwd, d);
        chk({tag, " ack_cycle"}, o_ack_c, gdly + 2);
      end else if (rnever) begin
        chk({tag, " ack_cycle"}, o_ack_c, gdly + 1 + RF_TIMEOUT + 1);
        chk({tag, " rdata"}, o_data, 32'h0);
        m_err = 1'b1;
      end else begin
        chk({tag, " ack_cycle"}, o_ack_c, gdly + rdly + 2);
        chk({tag, " rdata"}, o_data, rval);
      end
    end else begin
      chk({tag, " no_req"}, o_req_c, 0);
      chk({tag, " ack_cycle"}, o_ack_c, 2);
      if (!w) chk({tag, " rdata"}, o_data, exp_local);
      if (m_is_core(a)) m_err = 1'b1;
      else if (w && a == 16'h0000) begin
        m_halt = d[0]; m_sste = d[1]; m_step_done = 1'b0;
      end else if (w && a == 16'h0004 && d[2]) begin
        m_err = 1'b0;
      end
    end
    chk({tag, " single_ack"}, {31'b0, o_extra_ack}, 32'h0);
    chk({tag, " no_step"}, o_steps, 0);
    chk({tag, " halt"}, {31'b0, o_halt_x}, {31'b0, m_halt});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ack"}, {31'b0, dbg_ack_o}, 32'h0);
    chk({tag, " data"}, dbg_data_o, 32'h0);
    chk({tag, " halt"}, {31'b0, dbg_halt_o}, 32'h0);
    chk({tag, " step"}, {31'b0, dbg_step_o}, 32'h0);
    chk({tag, " req"}, {31'b0, rf_req_o}, 32'h0);
    chk({tag, " rf_we"}, {31'b0, rf_we_o}, 32'h0);
    chk({tag, " rf_addr"}, {26'b0, rf_addr_o}, 32'h0);
    chk({tag, " rf_wdata"}, rf_wdata_o, 32'h0);
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] d;
    logic w;
    int pick;

    rst = 1'b1; dbg_addr_i = '0; dbg_data_i = '0; dbg_we_i = 1'b0; dbg_stb_i = 1'b0;
    core_halted_i = 1'b0; rf_gnt_i = 1'b0; rf_rvalid_i = 1'b0; rf_rdata_i = '0;
    m_halt = 1'b0; m_sste = 1'b0; m_err = 1'b0; m_step_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // CTRL write/read, halt follows
    expect_txn("ctrl_wr", 16'h0000, 1'b1, 32'h1, 0, 0, 0, 0);
    expect_txn("ctrl_rd", 16'h0000, 1'b0, 32'h0, 0, 0, 0, 0);

    // Halted GPR1 read, immediate grant, rvalid two cycles later
    core_halted_i = 1'b1;
    expect_txn("gpr1_rd", 16'h0404, 1'b0, 32'h0, 0, 2, 0, 32'hCAFEF00D);

    // Halted PC write, grant delayed three cycles
    expect_txn("pc_wr", 16'h0008, 1'b1, 32'h12345678, 3, 0, 0, 0);

    // Core-register access while running: refused, ERR set, then cleared
    core_halted_i = 1'b0;
    expect_txn("gpr0_run", 16'h0400, 1'b0, 32'h0, 0, 0, 0, 0);
    expect_txn("stat_err", 16'h0004, 1'b0, 32'h0, 0, 0, 0, 0);
    expect_txn("stat_w1c", 16'h0004, 1'b1, 32'h4, 0, 0, 0, 0);
    expect_txn("stat_clr", 16'h0004, 1'b0, 32'h0, 0, 0, 0, 0);

    // Read timeout on the last GPR
    core_halted_i = 1'b1;
    expect_txn("gpr31_tmo", 16'h047C, 1'b0, 32'h0, 1, 0, 1, 0);
    expect_txn("stat_tmo", 16'h0004, 1'b0, 32'h0, 0, 0, 0, 0);
    expect_txn("stat_w1c2", 16'h0004, 1'b1, 32'h4, 0, 0, 0, 0);

    // Single step: halt low one cycle with one step pulse, then halt again
    run_txn(16'h0000, 1'b1, 32'h2, 0, 0, 0, 0);
    chk("step ack_cycle", o_ack_c, 2);
    chk("step halt_in_ack", {31'b0, o_halt_ack}, 32'h1);
    chk("step pulses", o_steps, 1);
    chk("step halt_low", {31'b0, o_halt_x}, 32'h0);
    m_sste = 1'b1; m_step_done = 1'b0;
    @(posedge clk); #1;
    chk("step halt_back", {31'b0, dbg_halt_o}, 32'h1);
    chk("step pulse_end", {31'b0, dbg_step_o}, 32'h0);
    core_halted_i = 1'b0;
    @(posedge clk); #1;
    core_halted_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_step_done = 1'b1;
    expect_txn("stat_step", 16'h0004, 1'b0, 32'h0, 0, 0, 0, 0);
    expect_txn("ctrl_rd2", 16'h0000, 1'b0, 32'h0, 0, 0, 0, 0);
    expect_txn("ctrl_wr2", 16'h0000, 1'b1, 32'h1, 0, 0, 0, 0);
    expect_txn("stat_nostep", 16'h0004, 1'b0, 32'h0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      core_halted_i = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      pick = $urandom_range(0, 6);
      case (pick)
        0: a = 16'h0000;
        1: a = 16'h0004;
        2: a = 16'h0008;
        3, 4: a = 16'(16'h0400 + 4 * $urandom_range(0, 31));
        5: a = 16'(16'h0400 + 4 * $urandom_range(0, 31) + $urandom_range(1, 3));
        default: begin
          case ($urandom_range(0, 3))
            0: a = 16'h000C;
            1: a = 16'h0480;
            2: a = 16'h0100;
            default: a = 16'hFFFC;
          endcase
        end
      endcase
      if (a == 16'h0000 && w && core_halted_i && d[1:0] == 2'b10) d[0] = 1'b1;
      expect_txn("rand", a, w, d, $urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom);
    end

    // Reset while waiting for read data
    core_halted_i = 1'b1;
    dbg_addr_i = 16'h0400; dbg_we_i = 1'b0; dbg_data_i = '0; dbg_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid req", {31'b0, rf_req_o}, 32'h1);
    rf_gnt_i = 1'b1;
    @(posedge clk); #1;
    rf_gnt_i = 1'b0;
    chk("rst_mid wait_noack", {31'b0, dbg_ack_o}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    chk("rst_mid hold_ack", {31'b0, dbg_ack_o}, 32'h0);
    dbg_stb_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid after_ack", {31'b0, dbg_ack_o}, 32'h0);
    chk("rst_mid after_req", {31'b0, rf_req_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
